// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (requesters plus the memory that drives readData).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // requester 0 (CPU memory stage)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  // requester 1 (DMA / debug loader)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  // shared response
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  // memory side
  logic [ADDR_W-1:0] memAddr;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  readData,
    output ack0, ack1, err, rdata, busy,
    output memAddr, memWrite, memRead, writeData
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output readData,
    input  ack0, ack1, err, rdata, busy,
    input  memAddr, memWrite, memRead, writeData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, byte-addressed
// data memory. One word access in flight: IDLE -> ACCESS -> RESP -> IDLE.
// All memory-side and requester-side outputs are registered.
module dmem_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES_PER_WORD - 1);
  // Highest byte address at which a whole word still fits in memory.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'((2 ** ADDR_W) - BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  logic              last;     // requester served most recently
  logic              winner;   // requester of the transaction in flight
  logic              curWe;
  logic              curBad;

  logic              grant1;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              selBad;

  // Round-robin pick and legality check of the candidate request
  always_comb begin
    grant1   = bus.req1 && (!bus.req0 || !last);
    selWe    = grant1 ? bus.we1    : bus.we0;
    selAddr  = grant1 ? bus.addr1  : bus.addr0;
    selWdata = grant1 ? bus.wdata1 : bus.wdata0;
    selBad   = (ALIGN_CHECK && ((selAddr & ALIGN_MASK) != '0)) ||
               (selAddr > MAX_ADDR);
  end

  // Transaction FSM with registered memory strobes and responses.
  // last is updated on entry to RESP rather than during it; nothing can
  // observe the difference because arbitration only happens in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last          <= 1'b1;
      winner        <= 1'b0;
      curWe         <= 1'b0;
      curBad        <= 1'b0;
      bus.memAddr   <= '0;
      bus.writeData <= '0;
      bus.memWrite  <= 1'b0;
      bus.memRead   <= 1'b0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            winner        <= grant1;
            curWe         <= selWe;
            curBad        <= selBad;
            bus.memAddr   <= selAddr;
            bus.writeData <= selWdata;
            bus.memWrite  <= selWe && !selBad;
            bus.memRead   <= !selWe && !selBad;
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.memWrite <= 1'b0;
          bus.memRead  <= 1'b0;
          if (!curWe && !curBad) begin
            bus.rdata <= bus.readData;
          end
          bus.ack0 <= !winner;
          bus.ack1 <= winner;
          bus.err  <= curBad;
          last     <= winner;
          state    <= RESP;
        end
        RESP: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.memWrite <= 1'b0;
          bus.memRead  <= 1'b0;
          bus.ack0     <= 1'b0;
          bus.ack1     <= 1'b0;
          bus.err      <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-array memory model on the
// memory side and a transaction-level reference (expected memory image,
// round-robin pointer, last read result) for the requester side.
module tb_dmem_arbiter;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NBYTES = 32;
  localparam int NB     = 4;

  logic clk = 1'b0;
  logic reset;
  logic loadMem;
  int   vectors = 0;
  int   miscompares = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ALIGN_CHECK(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory environment and reference model state
  logic [7:0]    mem    [NBYTES];
  logic [7:0]    refMem [NBYTES];
  bit            modelLast;
  logic [DW-1:0] expRdata;
  logic [AW-1:0] snapAddr;
  logic [DW-1:0] snapWd;

  // Memory write port (also loads the initial image during reset)
  always @(posedge clk) begin
    if (loadMem) begin
      for (int k = 0; k < NBYTES; k++) mem[k] <= refMem[k];
    end else if (bus.memWrite) begin
      for (int k = 0; k < NB; k++)
        mem[(int'(bus.memAddr) + k) % NBYTES] <= bus.writeData[8*k +: 8];
    end
  end

  // Combinational little-endian word read
  always_comb begin
    for (int k = 0; k < NB; k++)
      bus.readData[8*k +: 8] = mem[(int'(bus.memAddr) + k) % NBYTES];
  end

  // Snapshot of memory-side bus just after each edge
  always @(posedge clk) begin
    #1;
    snapAddr = bus.memAddr;
    snapWd   = bus.writeData;
  end

  // Protocol monitor, every cycle away from the edge
  always @(negedge clk) begin
    if (!reset) begin
      vectors++;
      if (bus.memWrite && bus.memRead) begin
        miscompares++;
        $display("FAIL strobes_exclusive: memWrite=%b memRead=%b required not both 1",
                 bus.memWrite, bus.memRead);
      end
      vectors++;
      if (bus.ack0 && bus.ack1) begin
        miscompares++;
        $display("FAIL acks_exclusive: ack0=%b ack1=%b required not both 1", bus.ack0, bus.ack1);
      end
      vectors++;
      if (!bus.busy && (bus.memWrite || bus.memRead)) begin
        miscompares++;
        $display("FAIL strobe_when_idle: memWrite=%b memRead=%b required 0 while idle",
                 bus.memWrite, bus.memRead);
      end
      vectors++;
      if (bus.err && !(bus.ack0 || bus.ack1)) begin
        miscompares++;
        $display("FAIL err_without_ack: err=%b required only with an ack", bus.err);
      end
      if (bus.memWrite || bus.memRead) begin
        vectors++;
        if (bus.memAddr !== snapAddr || bus.writeData !== snapWd) begin
          miscompares++;
          $display("FAIL strobe_stability: addr=%0h wd=%0h required addr=%0h wd=%0h",
                   bus.memAddr, bus.writeData, snapAddr, snapWd);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] refWord(input int a);
    logic [DW-1:0] w;
    for (int k = 0; k < NB; k++) w[8*k +: 8] = refMem[(a + k) % NBYTES];
    return w;
  endfunction

  function automatic bit refBad(input int a);
    return ((a % NB) != 0) || (a > NBYTES - NB);
  endfunction

  task automatic modelTxn(input int id, input bit we, input int a, input logic [DW-1:0] wd,
                          output bit expErr, output logic [DW-1:0] expData);
    expErr = refBad(a);
    if (!expErr) begin
      if (we) begin
        for (int k = 0; k < NB; k++) refMem[a + k] = wd[8*k +: 8];
      end else begin
        expRdata = refWord(a);
      end
    end
    expData   = expRdata;
    modelLast = (id == 1);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int id, input bit on, input bit we, input int a,
                        input logic [DW-1:0] wd);
    if (id == 0) begin
      bus.req0 = on; bus.we0 = we; bus.addr0 = AW'(a); bus.wdata0 = wd;
    end else begin
      bus.req1 = on; bus.we1 = we; bus.addr1 = AW'(a); bus.wdata1 = wd;
    end
  endtask

  // Waits (bounded) for any ack; lat counts edges from the call, 0 on timeout
  task automatic waitAck(output bit a0, output bit a1, output bit e, output logic [DW-1:0] d,
                         output int lat, output int rc, output int wc);
    a0 = 0; a1 = 0; e = 0; d = '0; lat = 0; rc = 0; wc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.memRead) rc++;
      if (bus.memWrite) wc++;
      if (bus.ack0 || bus.ack1) begin
        a0 = bus.ack0; a1 = bus.ack1; e = bus.err; d = bus.rdata; lat = c;
        break;
      end
    end
  endtask

  // Single-requester transaction: request, wait for ack, drop req, return to IDLE
  task automatic txn(input int id, input bit we, input int a, input logic [DW-1:0] wd,
                     output bit a0, output bit a1, output bit e, output logic [DW-1:0] d,
                     output int lat, output int rc, output int wc);
    setReq(id, 1'b1, we, a, wd);
    waitAck(a0, a1, e, d, lat, rc, wc);
    setReq(id, 1'b0, 1'b0, 0, '0);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    loadMem = 1'b1;
    setReq(0, 1'b0, 1'b0, 0, '0);
    setReq(1, 1'b0, 1'b0, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.memWrite, bus.memRead, bus.ack0, bus.ack1, bus.err, bus.busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.memWrite, bus.memRead, bus.ack0, bus.ack1, bus.err, bus.busy});
    end
    vectors++;
    if (bus.rdata !== '0) begin
      miscompares++; $display("FAIL reset_rdata: got %0h required 0", bus.rdata);
    end
    vectors++;
    if (bus.memAddr !== '0) begin
      miscompares++; $display("FAIL reset_memAddr: got %0h required 0", bus.memAddr);
    end
    vectors++;
    if (bus.writeData !== '0) begin
      miscompares++; $display("FAIL reset_writeData: got %0h required 0", bus.writeData);
    end
    @(negedge clk);
    reset = 1'b0;
    loadMem = 1'b0;
    modelLast = 1'b1;
    expRdata = '0;
    tick();
  endtask

  task automatic test_read_basic();
    bit a0, a1, e, expErr; logic [DW-1:0] d, expData; int lat, rc, wc;
    txn(0, 1'b0, 0, '0, a0, a1, e, d, lat, rc, wc);
    modelTxn(0, 1'b0, 0, '0, expErr, expData);
    vectors++;
    if ({a1, a0} !== 2'b01 || lat != 2) begin
      miscompares++;
      $display("FAIL read_basic_ack: acks=%b lat=%0d required 01 lat=2", {a1, a0}, lat);
    end
    vectors++;
    if (rc != 1 || wc != 0) begin
      miscompares++;
      $display("FAIL read_basic_strobe: rd=%0d wr=%0d cycles required 1/0", rc, wc);
    end
    vectors++;
    if (d !== 32'd15 || e !== expErr) begin
      miscompares++;
      $display("FAIL read_basic_data: rdata=%0h err=%b required f err=%b", d, e, expErr);
    end
  endtask

  task automatic test_write_read();
    bit a0, a1, e, expErr; logic [DW-1:0] d, expData; int lat, rc, wc;
    txn(1, 1'b1, 8, 32'hDEADBEEF, a0, a1, e, d, lat, rc, wc);
    modelTxn(1, 1'b1, 8, 32'hDEADBEEF, expErr, expData);
    vectors++;
    if ({a1, a0} !== 2'b10 || lat != 2 || wc != 1 || rc != 0) begin
      miscompares++;
      $display("FAIL write_ack: acks=%b lat=%0d wr=%0d rd=%0d required 10 2 1 0",
               {a1, a0}, lat, wc, rc);
    end
    vectors++;
    if (d !== expData || e !== expErr) begin
      miscompares++;
      $display("FAIL write_rdata_kept: rdata=%0h err=%b required %0h err=%b", d, e, expData, expErr);
    end
    txn(1, 1'b0, 8, '0, a0, a1, e, d, lat, rc, wc);
    modelTxn(1, 1'b0, 8, '0, expErr, expData);
    vectors++;
    if ({a1, a0} !== 2'b10 || d !== 32'hDEADBEEF || e !== 1'b0) begin
      miscompares++;
      $display("FAIL readback: acks=%b rdata=%0h err=%b required 10 deadbeef 0", {a1, a0}, d, e);
    end
  endtask

  task automatic test_round_robin();
    int expId, cnt, prevC; bit expErr; logic [DW-1:0] expData;
    expId = modelLast ? 0 : 1;
    cnt = 0;
    prevC = 0;
    setReq(0, 1'b1, 1'b0, 4, '0);
    setReq(1, 1'b1, 1'b0, 16, '0);
    for (int c = 1; c <= 40 && cnt < 4; c++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        modelTxn(expId, 1'b0, (expId == 0) ? 4 : 16, '0, expErr, expData);
        vectors++;
        if ({bus.ack1, bus.ack0} !== ((expId == 1) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL rr_grant%0d: acks=%b required requester %0d", cnt, {bus.ack1, bus.ack0}, expId);
        end
        vectors++;
        if (bus.rdata !== expData) begin
          miscompares++;
          $display("FAIL rr_data%0d: rdata=%0h required %0h", cnt, bus.rdata, expData);
        end
        if (cnt > 0) begin
          vectors++;
          if (c - prevC != 3) begin
            miscompares++;
            $display("FAIL rr_spacing%0d: %0d cycles required 3", cnt, c - prevC);
          end
        end
        prevC = c;
        cnt++;
        expId = 1 - expId;
        if (cnt == 4) begin
          setReq(0, 1'b0, 1'b0, 0, '0);
          setReq(1, 1'b0, 1'b0, 0, '0);
        end
      end
    end
    setReq(0, 1'b0, 1'b0, 0, '0);
    setReq(1, 1'b0, 1'b0, 0, '0);
    vectors++;
    if (cnt != 4) begin
      miscompares++; $display("FAIL rr_count: %0d acks required 4", cnt);
    end
    tick();
  endtask

  task automatic test_errors();
    bit a0, a1, e, expErr; logic [DW-1:0] d, expData; int lat, rc, wc;
    int addrs[3];
    bit wes[3];
    addrs = '{5, 30, 6};
    wes   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      txn(0, wes[i], addrs[i], 32'hA5A5_0000 + DW'(i), a0, a1, e, d, lat, rc, wc);
      modelTxn(0, wes[i], addrs[i], 32'hA5A5_0000 + DW'(i), expErr, expData);
      vectors++;
      if ({a1, a0} !== 2'b01 || e !== expErr || lat != 2) begin
        miscompares++;
        $display("FAIL err_ack_a%0d: acks=%b err=%b lat=%0d required 01 %b 2",
                 addrs[i], {a1, a0}, e, lat, expErr);
      end
      vectors++;
      if (rc != 0 || wc != 0) begin
        miscompares++;
        $display("FAIL err_strobe_a%0d: rd=%0d wr=%0d required 0 0", addrs[i], rc, wc);
      end
      vectors++;
      if (d !== expData) begin
        miscompares++;
        $display("FAIL err_rdata_a%0d: rdata=%0h required %0h", addrs[i], d, expData);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit a0, a1, e, expErr, ackSeen; logic [DW-1:0] d, expData, wd; int lat, rc, wc;
    wd = $urandom;
    setReq(0, 1'b1, 1'b1, 12, wd);
    tick();
    vectors++;
    if (bus.memWrite !== 1'b1) begin
      miscompares++; $display("FAIL abort_strobe_on: memWrite=%b required 1", bus.memWrite);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.memWrite !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async: memWrite=%b busy=%b required 0 0", bus.memWrite, bus.busy);
    end
    vectors++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      miscompares++; $display("FAIL abort_ack: acks=%b required 00", {bus.ack1, bus.ack0});
    end
    setReq(0, 1'b0, 1'b0, 0, '0);
    @(negedge clk);
    reset = 1'b0;
    modelLast = 1'b1;
    expRdata = '0;
    ackSeen = 0;
    repeat (3) begin
      tick();
      if (bus.ack0 || bus.ack1) ackSeen = 1;
    end
    vectors++;
    if (ackSeen) begin
      miscompares++; $display("FAIL abort_no_ack: ack seen=1 required 0");
    end
    // first tie after reset goes to requester 0; address 12 must be unwritten
    setReq(0, 1'b1, 1'b0, 12, '0);
    setReq(1, 1'b1, 1'b0, 16, '0);
    waitAck(a0, a1, e, d, lat, rc, wc);
    modelTxn(0, 1'b0, 12, '0, expErr, expData);
    vectors++;
    if ({a1, a0} !== 2'b01 || d !== expData || lat != 2) begin
      miscompares++;
      $display("FAIL abort_tie0: acks=%b rdata=%0h lat=%0d required 01 %0h 2", {a1, a0}, d, lat, expData);
    end
    setReq(0, 1'b0, 1'b0, 0, '0);
    tick();
    waitAck(a0, a1, e, d, lat, rc, wc);
    modelTxn(1, 1'b0, 16, '0, expErr, expData);
    vectors++;
    if ({a1, a0} !== 2'b10 || d !== expData || lat != 2) begin
      miscompares++;
      $display("FAIL abort_tie1: acks=%b rdata=%0h lat=%0d required 10 %0h 2", {a1, a0}, d, lat, expData);
    end
    setReq(1, 1'b0, 1'b0, 0, '0);
    tick();
  endtask

  task automatic test_random();
    bit pend[2]; bit pWe[2]; int pAddr[2]; logic [DW-1:0] pWd[2];
    bit a0, a1, e, expErr; logic [DW-1:0] d, expData; int lat, rc, wc, w;
    pend[0] = 0;
    pend[1] = 0;
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r]  = 1;
          pWe[r]   = 1'($urandom_range(0, 1));
          pAddr[r] = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, 7) : $urandom_range(0, 31);
          pWd[r]   = $urandom;
          setReq(r, 1'b1, pWe[r], pAddr[r], pWd[r]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1; pWe[0] = 1'b0; pAddr[0] = 4 * $urandom_range(0, 7); pWd[0] = '0;
        setReq(0, 1'b1, pWe[0], pAddr[0], pWd[0]);
      end
      w = (pend[0] && pend[1]) ? (modelLast ? 0 : 1) : (pend[1] ? 1 : 0);
      waitAck(a0, a1, e, d, lat, rc, wc);
      modelTxn(w, pWe[w], pAddr[w], pWd[w], expErr, expData);
      vectors++;
      if ({a1, a0} !== ((w == 1) ? 2'b10 : 2'b01) || lat != 2) begin
        miscompares++;
        $display("FAIL rand%0d_grant: acks=%b lat=%0d required requester %0d lat=2", it, {a1, a0}, lat, w);
      end
      vectors++;
      if (e !== expErr) begin
        miscompares++;
        $display("FAIL rand%0d_err: err=%b required %b (addr %0d)", it, e, expErr, pAddr[w]);
      end
      vectors++;
      if (d !== expData) begin
        miscompares++;
        $display("FAIL rand%0d_rdata: rdata=%0h required %0h", it, d, expData);
      end
      setReq(w, 1'b0, 1'b0, 0, '0);
      pend[w] = 0;
      tick();
    end
    setReq(0, 1'b0, 1'b0, 0, '0);
    setReq(1, 1'b0, 1'b0, 0, '0);
    repeat (4) tick();
    for (int a = 0; a < NBYTES; a += NB) begin
      logic [DW-1:0] got;
      for (int k = 0; k < NB; k++) got[8*k +: 8] = mem[a + k];
      vectors++;
      if (got !== refWord(a)) begin
        miscompares++;
        $display("FAIL mem_image_a%0d: memory=%0h required %0h", a, got, refWord(a));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < NBYTES; a += NB) begin
      logic [DW-1:0] w;
      w = (a == 0) ? 32'd15 : $urandom;
      for (int k = 0; k < NB; k++) refMem[a + k] = w[8*k +: 8];
    end
    test_reset();
    test_read_basic();
    test_write_read();
    test_round_robin();
    test_errors();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
